// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use detection, MUL/DIV sequencing with
// write-back slot ownership, and EX redirect flushes.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_reg_wb_i,
  input  logic [2:0] id_fu_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       redirect_i,
  output logic       stall_o,
  output logic       flush_if_o,
  output logic       flush_id_o,
  output logic       md_start_o,
  output logic       md_busy_o,
  output logic [4:0] md_rd_o,
  output logic       md_wb_sel_o
);

  localparam logic [2:0] FU_MUL = 3'd4;
  localparam logic [2:0] FU_DIV = 3'd5;
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [4:0]    md_rd;
  logic          md_wb;
  logic          md_busy;

  logic is_md;
  logic load_use;
  logic md_dep;
  logic structural;
  logic port_steal;
  logic hazard;
  logic issue;

  assign is_md = (id_fu_i == FU_MUL) || (id_fu_i == FU_DIV);

  assign load_use = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

  // md_wb is only set for rd!=0, so x0 never matches an in-flight result.
  assign md_dep = md_busy && md_wb &&
                  ((id_rs1_used_i && (id_rs1_i == md_rd)) ||
                   (id_rs2_used_i && (id_rs2_i == md_rd)) ||
                   (id_reg_wb_i   && (id_rd_i  == md_rd)));

  assign structural = is_md && (state != IDLE);
  assign port_steal = (state == WB) && md_wb;
  assign hazard     = load_use || md_dep || structural || port_steal;

  // Combinational outputs are forced low while reset is held.
  assign stall_o     = rst_ni && id_valid_i && !redirect_i && hazard;
  assign flush_if_o  = rst_ni && redirect_i;
  assign flush_id_o  = rst_ni && (redirect_i || stall_o);
  assign issue       = id_valid_i && !stall_o && !redirect_i;
  assign md_start_o  = rst_ni && issue && is_md && (state == IDLE);
  assign md_wb_sel_o = (state == WB) && md_wb;
  assign md_busy_o   = md_busy;
  assign md_rd_o     = md_rd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      count   <= '0;
      md_rd   <= 5'd0;
      md_wb   <= 1'b0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && is_md) begin
            state   <= BUSY;
            count   <= (id_fu_i == FU_MUL) ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
            md_rd   <= id_rd_i;
            md_wb   <= id_reg_wb_i && (id_rd_i != 5'd0);
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state <= WB;
          end else begin
            count <= count - CW'(1);
          end
        end
        WB: begin
          state   <= IDLE;
          md_rd   <= 5'd0;
          md_wb   <= 1'b0;
          md_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          md_rd   <= 5'd0;
          md_wb   <= 1'b0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked each
// cycle against a model that tracks MUL/DIV sequences by issue cycle number.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = 5'd0;
  logic [4:0] id_rs2_i = 5'd0;
  logic       id_rs1_used_i = 1'b0;
  logic       id_rs2_used_i = 1'b0;
  logic [4:0] id_rd_i = 5'd0;
  logic       id_reg_wb_i = 1'b0;
  logic [2:0] id_fu_i = 3'd0;
  logic       ex_valid_i = 1'b0;
  logic       ex_mem_read_i = 1'b0;
  logic [4:0] ex_rd_i = 5'd0;
  logic       redirect_i = 1'b0;
  logic       stall_o;
  logic       flush_if_o;
  logic       flush_id_o;
  logic       md_start_o;
  logic       md_busy_o;
  logic [4:0] md_rd_o;
  logic       md_wb_sel_o;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_reg_wb_i(id_reg_wb_i), .id_fu_i(id_fu_i),
    .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .redirect_i(redirect_i),
    .stall_o(stall_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .md_start_o(md_start_o), .md_busy_o(md_busy_o), .md_rd_o(md_rd_o),
    .md_wb_sel_o(md_wb_sel_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: an active sequence issued at cycle m_iss owns the write port at m_iss+lat+1.
  bit         m_active = 1'b0;
  int         m_iss = 0;
  int         m_lat = 0;
  logic [4:0] m_rd = 5'd0;
  bit         m_wb = 1'b0;
  bit         exp_start_q = 1'b0;
  bit         exp_in_wb_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input bit v, input int fu, input int rd, input bit wb,
                                input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid_i    = v;
    id_fu_i       = 3'(fu);
    id_rd_i       = 5'(rd);
    id_reg_wb_i   = wb;
    id_rs1_i      = 5'(rs1);
    id_rs1_used_i = u1;
    id_rs2_i      = 5'(rs2);
    id_rs2_used_i = u2;
  endtask

  task automatic set_ex(input bit v, input bit mr, input int rd);
    ex_valid_i    = v;
    ex_mem_read_i = mr;
    ex_rd_i       = 5'(rd);
  endtask

  task automatic check_output();
    int  wbc;
    bit  busy, in_wb, is_md, ld, raw, structural, steal, stl, iss, start;
    wbc        = m_iss + m_lat + 1;
    busy       = m_active && (cyc > m_iss) && (cyc <= wbc);
    in_wb      = m_active && (cyc == wbc);
    is_md      = (id_fu_i == 3'd4) || (id_fu_i == 3'd5);
    ld         = ex_valid_i && ex_mem_read_i && (ex_rd_i != 0) &&
                 ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
    raw        = busy && m_wb &&
                 ((id_rs1_used_i && id_rs1_i == m_rd) || (id_rs2_used_i && id_rs2_i == m_rd) ||
                  (id_reg_wb_i && id_rd_i == m_rd));
    structural = is_md && busy;
    steal      = in_wb && m_wb;
    stl        = id_valid_i && !redirect_i && (ld || raw || structural || steal);
    iss        = id_valid_i && !stl && !redirect_i;
    start      = iss && is_md && !busy;
    check("stall", stall_o, stl);
    check("flush_if", flush_if_o, redirect_i);
    check("flush_id", flush_id_o, redirect_i || stl);
    check("md_start", md_start_o, start);
    check("md_busy", md_busy_o, busy);
    check("md_rd", md_rd_o, busy ? m_rd : 5'd0);
    check("md_wb_sel", md_wb_sel_o, in_wb && m_wb);
    exp_start_q = start;
    exp_in_wb_q = in_wb;
  endtask

  task automatic step();
    @(negedge clk_i);
    check_output();
    @(posedge clk_i);
    if (exp_start_q) begin
      m_active = 1'b1;
      m_iss    = cyc;
      m_lat    = (id_fu_i == 3'd4) ? MUL_LAT : DIV_LAT;
      m_rd     = id_rd_i;
      m_wb     = id_reg_wb_i && (id_rd_i != 0);
    end else if (exp_in_wb_q) begin
      m_active = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_id();
    apply_stimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int n;
    #2;
    check("rst_stall", stall_o, 0);
    check("rst_busy", md_busy_o, 0);
    check("rst_rd", md_rd_o, 0);
    check("rst_wb_sel", md_wb_sel_o, 0);
    #10 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Load-use on x5, then the same with ex_rd=x0.
    set_ex(1'b1, 1'b1, 5);
    apply_stimulus(1'b1, 0, 6, 1'b1, 5, 1'b1, 1, 1'b1);
    step();
    set_ex(1'b1, 1'b1, 0);
    apply_stimulus(1'b1, 0, 6, 1'b1, 0, 1'b1, 1, 1'b1);
    step();
    set_ex(1'b0, 1'b0, 0);
    step();

    // mul x7, independent add in cycle 2.
    apply_stimulus(1'b1, 4, 7, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    idle_id();
    step();
    apply_stimulus(1'b1, 0, 8, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    idle_id();
    repeat (3) step();

    // div x9 followed by a reader of x9.
    apply_stimulus(1'b1, 5, 9, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    apply_stimulus(1'b1, 0, 10, 1'b1, 9, 1'b1, 0, 1'b0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!stall_o) break;
      n++;
      step();
    end
    check("div_raw_stall_cycles", n, DIV_LAT + 1);
    step();
    idle_id();
    step();

    // Structural: back-to-back muls, then mul x0.
    apply_stimulus(1'b1, 4, 11, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    apply_stimulus(1'b1, 4, 12, 1'b1, 1, 1'b1, 2, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (md_start_o) break;
      n++;
      step();
    end
    check("struct_wait_cycles", n, MUL_LAT + 1);
    step();
    apply_stimulus(1'b1, 4, 0, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    step();
    apply_stimulus(1'b1, 4, 0, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    apply_stimulus(1'b1, 0, 3, 1'b1, 0, 1'b1, 0, 1'b1);
    repeat (5) step();

    // Redirect during a load-use stall with a MUL in ID.
    set_ex(1'b1, 1'b1, 5);
    apply_stimulus(1'b1, 4, 13, 1'b1, 5, 1'b1, 1, 1'b1);
    step();
    redirect_i = 1'b1;
    step();
    redirect_i = 1'b0;
    set_ex(1'b0, 1'b0, 0);
    idle_id();
    step();

    // Reset asserted 10 cycles into a DIV.
    apply_stimulus(1'b1, 5, 14, 1'b1, 1, 1'b1, 2, 1'b1);
    step();
    idle_id();
    repeat (9) step();
    set_ex(1'b1, 1'b1, 5);
    apply_stimulus(1'b1, 5, 15, 1'b1, 5, 1'b1, 14, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("arst_stall", stall_o, 0);
    check("arst_flush_id", flush_id_o, 0);
    check("arst_start", md_start_o, 0);
    check("arst_busy", md_busy_o, 0);
    check("arst_rd", md_rd_o, 0);
    check("arst_wb_sel", md_wb_sel_o, 0);
    #2 rst_ni = 1'b1;
    m_active = 1'b0;
    set_ex(1'b0, 1'b0, 0);
    idle_id();
    repeat (40) step();

    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      apply_stimulus($urandom_range(0, 7) != 0, $urandom_range(0, 6), $urandom_range(0, 3),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      set_ex($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      redirect_i = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the ID stage of the rv32 core.
- Detects load-use hazards and sequences the shared multi-cycle MUL/DIV unit, including its in-flight destination register and its write-back slot.
- Applies EX-stage redirect flushes.
- Drives decode's hazard_stall_i and the pipeline-register enables/flushes for IF/ID and ID/EX.

Parameters:
MUL_LAT, 3, cycles from MUL issue to result valid (>=1)
DIV_LAT, 34, cycles from DIV/REM issue to result valid (>=1)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a valid instruction
id_rs1_i  in  5  ID source register 1
id_rs2_i  in  5  ID source register 2
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_i  in  5  ID destination register
id_reg_wb_i  in  1  ID instruction writes rd
id_fu_i  in  3  ID functional unit select (FU_ALU=0 … FU_MUL=4, FU_DIV=5, FU_CSR=6)
ex_valid_i  in  1  EX holds a valid instruction
ex_mem_read_i  in  1  EX instruction is a load
ex_rd_i  in  5  EX destination register
redirect_i  in  1  EX resolved taken branch/jump
stall_o  out  1  hold PC and IF/ID; equals decode hazard_stall_i
flush_if_o  out  1  squash IF/ID register
flush_id_o  out  1  insert bubble into ID/EX
md_start_o  out  1  one-cycle start pulse to MUL/DIV unit
md_busy_o  out  1  MUL/DIV sequence in progress
md_rd_o  out  5  destination of in-flight MUL/DIV
md_wb_sel_o  out  1  RF write port owned by MUL/DIV this cycle

Behaviour:
- Reset (async, rst_ni=0): state IDLE, counter 0, md_rd 0; every output 0. Reset mid-sequence abandons the operation; no md_wb_sel_o pulse follows.
- issue = id_valid_i & ~stall_o & ~redirect_i.
- States:
  - IDLE: on issue with id_fu_i=FU_MUL, go to BUSY with counter=MUL_LAT-1; with FU_DIV, counter=DIV_LAT-1. In both cases latch md_rd=id_rd_i and md_wb=id_reg_wb_i&(id_rd_i!=0), and md_start_o=1 in that same cycle (combinational).
  - BUSY: counter decrements each cycle. When counter==0, go to WB. A latency of 1 therefore spends one BUSY cycle.
  - WB: md_wb_sel_o=md_wb for exactly one cycle, then IDLE.
- md_busy_o=1 in BUSY and WB. md_rd_o holds the latched value, else 0.
- stall_o=1 if id_valid_i and any of the following holds:
  - Load-use: ex_valid_i & ex_mem_read_i & ex_rd_i!=0 & (rs1_used & rs1==ex_rd_i | rs2_used & rs2==ex_rd_i).
  - MUL/DIV RAW/WAW: md_busy & md_wb & (rs1_used & rs1==md_rd | rs2_used & rs2==md_rd | id_reg_wb & id_rd==md_rd).
  - Structural: id_fu_i in {MUL,DIV} & state!=IDLE.
  - Write-port steal: state==WB & md_wb.
- Register x0 never creates a hazard.
- Redirect: redirect_i=1 forces flush_if_o=1, flush_id_o=1, stall_o=0 in the same cycle; the ID instruction does not issue. An in-flight MUL/DIV is older than the branch and continues to completion.
- When stall_o=1 and redirect_i=0: flush_id_o=1 (bubble into EX), flush_if_o=0.
- A non-MUL/DIV instruction issues freely while MUL/DIV is BUSY if it has no dependence.
- Simultaneous WB-exit and a new MUL/DIV in ID: the structural stall holds in WB. Issue occurs the following cycle (IDLE), giving back-to-back sequences with one gap cycle.
- All outputs are combinational from state and inputs except md_rd_o and md_busy_o, which are registered.

Test Plan:
- Load-use: EX = lw x5 (ex_mem_read_i=1, ex_rd_i=5), ID = add x6,x5,x1. Required: stall_o=1, flush_id_o=1 for 1 cycle. With ex_rd_i=0: no stall.
- MUL issue, MUL_LAT=3: ID = mul x7 while IDLE. Required: md_start_o pulse at cycle 0, BUSY for cycles 1-3, md_wb_sel_o=1 at cycle 4, idle at cycle 5. An independent add in cycle 2 issues without stall.
- DIV RAW: div x9 issued, then ID reads x9. Required: stall_o held through the WB cycle (DIV_LAT+1 stalled cycles), release the next cycle.
- Structural: second mul while BUSY. Required: stall until IDLE, then md_start_o. A mul x0 produces md_wb_sel_o=0 and no write-port stall.
- Redirect during load-use stall: redirect_i=1. Required: stall_o=0, flush_if_o=flush_id_o=1, no md_start_o even if ID is MUL.
- Async reset asserted mid-DIV (cycle 10). Required: all outputs 0 immediately, state IDLE after release, no md_wb_sel_o pulse.
